uart_threshold_bank: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_threshold_bank_if.sv | 20 ++
 rtl/uart_rsp_sequencer.sv | 72 +++++++
 rtl/uart_threshold_bank.sv | 201 ++++++++++++++++++++
 tb/tb_uart_threshold_bank.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared command constants, FSM state type and ASCII helper for the UART threshold bank.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_INC  = "w";
   localparam logic [7:0] CMD_DEC  = "s";
   localparam logic [7:0] CMD_READ = "r";
   localparam logic [7:0] CMD_LOCK = "x";
   localparam logic [7:0] CH_BASE  = "A";
   localparam logic [7:0] RSP_ERR  = "?";
   localparam logic [7:0] RSP_DENY = "!";
   localparam logic [7:0] CR       = 8'h0D;

   // Longest response: four hex digits plus CR.
   localparam int RSP_MAX = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_LOAD,
      ST_SEND,
      ST_WAIT
   } state_t;

   function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_threshold_bank_if.sv
// Byte-level link between the threshold bank and the uart_rx / uart_tx pair.
interface uart_threshold_bank_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_idle_ready;

   modport slave (
      input  rx_data, rx_valid, tx_idle_ready,
      output tx_data, tx_start
   );

   modport master (
      output rx_data, rx_valid, tx_idle_ready,
      input  tx_data, tx_start
   );

endinterface

// File: rtl/uart_rsp_sequencer.sv
// Streams a latched response buffer to uart_tx, one byte outstanding at a time.
module uart_rsp_sequencer
   import uart_cmd_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [RSP_MAX-1:0][7:0] rsp_buf,
   input  logic [2:0]              rsp_len,
   input  logic                    tx_idle_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   output logic                    done
);

   state_t                  state_reg, state_next;
   logic [RSP_MAX-1:0][7:0] buf_reg;
   logic [2:0]              len_reg;
   logic [2:0]              idx_reg;
   logic [7:0]              tx_data_reg;
   logic                    seen_low_reg;
   logic                    last_byte;

   assign last_byte = ((idx_reg + 3'd1) >= len_reg);

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_LOAD;
         ST_LOAD: state_next = ST_SEND;
         ST_SEND: if (tx_idle_ready) state_next = ST_WAIT;
         // A byte is only finished once the transmitter has gone busy and come back.
         ST_WAIT: if (seen_low_reg && tx_idle_ready) state_next = last_byte ? ST_IDLE : ST_LOAD;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state_reg == ST_SEND) && tx_idle_ready;
      done     = (state_reg == ST_WAIT) && seen_low_reg && tx_idle_ready && last_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_reg      <= '0;
         len_reg      <= '0;
         idx_reg      <= '0;
         tx_data_reg  <= '0;
         seen_low_reg <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && start) begin
            buf_reg <= rsp_buf;
            len_reg <= rsp_len;
            idx_reg <= '0;
         end
         if (state_reg == ST_LOAD) tx_data_reg <= buf_reg[idx_reg];
         if (state_reg == ST_SEND)
            seen_low_reg <= 1'b0;
         else if (state_reg == ST_WAIT && !tx_idle_ready)
            seen_low_reg <= 1'b1;
         if (state_reg == ST_WAIT && state_next == ST_LOAD) idx_reg <= idx_reg + 3'd1;
      end
   end

   assign tx_data = tx_data_reg;

endmodule

// File: rtl/uart_threshold_bank.sv
// ASCII-commanded bank of NUM_CH saturating threshold registers with hex read-back.
// Optional THRESH_LOCK_EN adds an 'x'-toggled lock that blocks 'w'/'s'.
module uart_threshold_bank
   import uart_cmd_pkg::*;
#(
   parameter int  NUM_CH    = 9,
   parameter int  TH_W      = 8,
   parameter int  STEP      = 1,
   parameter int  RESET_VAL = 2**(TH_W-1),
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                   clk,
   input  logic                   rst,
   uart_threshold_bank_if.slave   bus,
   output logic [NUM_CH*TH_W-1:0] th_flat,
   output logic [SEL_W-1:0]       sel_ch,
   output logic                   sel_valid,
   output logic                   err_pulse
);

   localparam int              HEX_DIGITS = (TH_W + 3) / 4;
   localparam logic [TH_W:0]   TH_MAX     = {1'b0, {TH_W{1'b1}}};
   localparam logic [TH_W:0]   STEP_EXT   = STEP[TH_W:0];
   localparam logic [TH_W-1:0] TH_RESET   = RESET_VAL[TH_W-1:0];

   state_t                  state_reg, state_next;
   logic [7:0]              cmd_reg;
   logic [TH_W-1:0]         th_reg [NUM_CH];
   logic [SEL_W-1:0]        sel_reg;
   logic                    sel_valid_reg;
   logic                    err_reg;
   logic                    exec_en;
   logic                    seq_done;
   logic [7:0]              ch_off;
   logic                    is_sel, is_th_cmd;
   logic [TH_W-1:0]         cur_th, inc_val, dec_val, new_th;
   logic [TH_W:0]           inc_sum, dec_diff;
   logic                    wr_en, sel_load, cmd_err, rsp_hex;
   logic [7:0]              rsp_byte;
   logic [4*HEX_DIGITS-1:0] hex_val;
   logic [7:0]              hex_chars [HEX_DIGITS];
   logic [RSP_MAX-1:0][7:0] rsp_buf;
   logic [2:0]              rsp_len;

`ifdef THRESH_LOCK_EN
   localparam logic [7:0] RSP_LOCKED   = "L";
   localparam logic [7:0] RSP_UNLOCKED = "U";
   logic lock_reg;
   logic lock_toggle;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // ST_WAIT here covers the whole response; the sequencer owns the byte-level handshake.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.rx_valid) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_WAIT;
         ST_WAIT: if (seq_done) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      exec_en = (state_reg == ST_EXEC);
   end

   assign ch_off    = cmd_reg - CH_BASE;
   assign is_sel    = (cmd_reg >= CH_BASE) && ({24'd0, ch_off} < 32'(NUM_CH));
   assign is_th_cmd = (cmd_reg == CMD_INC) || (cmd_reg == CMD_DEC) || (cmd_reg == CMD_READ);
   assign cur_th    = th_reg[sel_reg];

   // One spare bit keeps both directions free of wrap-around before clamping.
   always_comb begin
      inc_sum  = {1'b0, cur_th} + STEP_EXT;
      dec_diff = {1'b0, cur_th} - STEP_EXT;
      inc_val  = (inc_sum > TH_MAX) ? TH_MAX[TH_W-1:0] : inc_sum[TH_W-1:0];
      dec_val  = dec_diff[TH_W] ? '0 : dec_diff[TH_W-1:0];
   end

   always_comb begin
      wr_en    = 1'b0;
      sel_load = 1'b0;
      cmd_err  = 1'b0;
      rsp_hex  = 1'b0;
      rsp_byte = RSP_ERR;
      new_th   = cur_th;
`ifdef THRESH_LOCK_EN
      lock_toggle = 1'b0;
`endif
      if (is_sel) begin
         sel_load = 1'b1;
         rsp_byte = cmd_reg;
      end else if (is_th_cmd) begin
         if (!sel_valid_reg)
            cmd_err = 1'b1;
`ifdef THRESH_LOCK_EN
         else if (lock_reg && (cmd_reg != CMD_READ)) begin
            cmd_err  = 1'b1;
            rsp_byte = RSP_DENY;
         end
`endif
         else begin
            rsp_hex = 1'b1;
            if (cmd_reg == CMD_INC) begin
               new_th = inc_val;
               wr_en  = 1'b1;
            end else if (cmd_reg == CMD_DEC) begin
               new_th = dec_val;
               wr_en  = 1'b1;
            end
         end
      end
`ifdef THRESH_LOCK_EN
      else if (cmd_reg == CMD_LOCK) begin
         lock_toggle = 1'b1;
         rsp_byte    = lock_reg ? RSP_UNLOCKED : RSP_LOCKED;
      end
`endif
      else begin
         cmd_err = 1'b1;
      end
   end

   always_comb begin
      hex_val             = '0;
      hex_val[TH_W-1:0]   = new_th;
   end

   always_comb begin
      rsp_buf = '0;
      rsp_len = 3'd1;
      if (rsp_hex) begin
         for (int d = 0; d < HEX_DIGITS; d++) rsp_buf[d] = hex_chars[d];
         rsp_buf[HEX_DIGITS] = CR;
         rsp_len             = 3'(HEX_DIGITS + 1);
      end else begin
         rsp_buf[0] = rsp_byte;
      end
   end

   generate
      for (genvar gi = 0; gi < HEX_DIGITS; gi++) begin : g_hex
         assign hex_chars[gi] = hex_nibble_to_ascii(hex_val[4*(HEX_DIGITS-1-gi) +: 4]);
      end
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_th
         always_ff @(posedge clk) begin
            if (rst)
               th_reg[gi] <= TH_RESET;
            else if (exec_en && wr_en && (sel_reg == SEL_W'(gi)))
               th_reg[gi] <= new_th;
         end
         assign th_flat[gi*TH_W +: TH_W] = th_reg[gi];
      end
   endgenerate

   // Busy drops and rejected commands share the single error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_reg       <= '0;
         sel_reg       <= '0;
         sel_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && bus.rx_valid) cmd_reg <= bus.rx_data;
         if (exec_en && sel_load) begin
            sel_reg       <= ch_off[SEL_W-1:0];
            sel_valid_reg <= 1'b1;
         end
         err_reg <= (bus.rx_valid && (state_reg != ST_IDLE)) || (exec_en && cmd_err);
      end
   end

`ifdef THRESH_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) lock_reg <= 1'b0;
      else     lock_reg <= lock_reg ^ (exec_en & lock_toggle);
   end
`endif

   uart_rsp_sequencer u_seq (
      .clk           (clk),
      .rst           (rst),
      .start         (exec_en),
      .rsp_buf       (rsp_buf),
      .rsp_len       (rsp_len),
      .tx_idle_ready (bus.tx_idle_ready),
      .tx_data       (bus.tx_data),
      .tx_start      (bus.tx_start),
      .done          (seq_done)
   );

   assign sel_ch    = sel_reg;
   assign sel_valid = sel_valid_reg;
   assign err_pulse = err_reg;

endmodule

// File: tb/tb_uart_threshold_bank.sv
// Randomized self-checking bench for uart_threshold_bank against a command-level model.
module tb_uart_threshold_bank;

   localparam int NUM_CH     = 9;
   localparam int TH_W       = 8;
   localparam int STEP       = 1;
   localparam int RESET_VAL  = 128;
   localparam int SEL_W      = 4;
   localparam int TH_MAX     = 255;
   localparam int HEX_DIGITS = 2;
`ifdef THRESH_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NUM_CH*TH_W-1:0] th_flat;
   logic [SEL_W-1:0]       sel_ch;
   logic                   sel_valid;
   logic                   err_pulse;

   uart_threshold_bank_if bus();

   uart_threshold_bank #(
      .NUM_CH    (NUM_CH),
      .TH_W      (TH_W),
      .STEP      (STEP),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .th_flat   (th_flat),
      .sel_ch    (sel_ch),
      .sel_valid (sel_valid),
      .err_pulse (err_pulse)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Command-level reference model.
   int         m_th [NUM_CH];
   int         m_sel;
   bit         m_selv;
   bit         m_lock;
   logic [7:0] exp_q [$];
   int         exp_err;
   string      hexs = "0123456789ABCDEF";

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) m_th[k] = RESET_VAL;
      m_sel  = 0;
      m_selv = 1'b0;
      m_lock = 1'b0;
   endtask

   task automatic model_apply(input logic [7:0] c);
      int v;
      int ci = int'(c);
      exp_q.delete();
      exp_err = 0;
      if (ci >= 65 && ci < 65 + NUM_CH) begin
         m_sel  = ci - 65;
         m_selv = 1'b1;
         exp_q.push_back(c);
      end else if (c == "w" || c == "s" || c == "r") begin
         if (!m_selv) begin
            exp_q.push_back("?");
            exp_err = 1;
         end else if (m_lock && c != "r") begin
            exp_q.push_back("!");
            exp_err = 1;
         end else begin
            v = m_th[m_sel];
            if (c == "w") v = (v + STEP > TH_MAX) ? TH_MAX : v + STEP;
            if (c == "s") v = (v - STEP < 0) ? 0 : v - STEP;
            m_th[m_sel] = v;
            for (int d = HEX_DIGITS - 1; d >= 0; d--) exp_q.push_back(hexs[(v >> (4 * d)) & 15]);
            exp_q.push_back(8'h0D);
         end
      end else if (LOCK_EN && c == "x") begin
         m_lock = !m_lock;
         exp_q.push_back(m_lock ? "L" : "U");
      end else begin
         exp_q.push_back("?");
         exp_err = 1;
      end
   endtask

   // uart_tx stand-in: accepts on tx_start, then goes busy for a random few cycles.
   logic [7:0] rx_q [$];
   int         err_cnt = 0;
   bit         pending = 1'b0;
   int         busy_cnt = 0;

   always @(negedge clk) begin
      if (err_pulse === 1'b1) err_cnt++;
      if (rst) begin
         bus.tx_idle_ready = 1'b1;
         pending           = 1'b0;
         busy_cnt          = 0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) bus.tx_idle_ready = 1'b1;
      end else if (pending) begin
         pending           = 1'b0;
         bus.tx_idle_ready = 1'b0;
         busy_cnt          = $urandom_range(1, 3);
      end else if (bus.tx_start === 1'b1) begin
         rx_q.push_back(bus.tx_data);
         pending = 1'b1;
      end
   end

   task automatic check_state(input string tag);
      for (int k = 0; k < NUM_CH; k++)
         check($sformatf("%s th%0d", tag, k), th_flat[k*TH_W +: TH_W], m_th[k]);
      check({tag, " sel_valid"}, sel_valid, m_selv);
      if (m_selv) check({tag, " sel_ch"}, sel_ch, m_sel);
   endtask

   task automatic wait_bytes(input int n);
      int waited = 0;
      while (rx_q.size() < n && waited < 400) begin
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic do_cmd(input logic [7:0] c, input string tag, input bit inject);
      int e0;
      model_apply(c);
      rx_q.delete();
      e0 = err_cnt;
      @(negedge clk);
      bus.rx_data  = c;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (inject) begin
         wait_bytes(1);
         bus.rx_data  = "w";
         bus.rx_valid = 1'b1;
         @(negedge clk);
         bus.rx_valid = 1'b0;
         exp_err++;
      end
      wait_bytes(exp_q.size());
      repeat (10) @(negedge clk);
      check({tag, " rsp_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s byte%0d", tag, i), rx_q[i], exp_q[i]);
      check({tag, " err"}, err_cnt - e0, exp_err);
      check_state(tag);
      $display("[TB] cmd '%s' -> %0d byte(s), err %0d", string'(c), rx_q.size(), err_cnt - e0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst tx_start", bus.tx_start, 1'b0);
      check("rst tx_data", bus.tx_data, 8'h00);
      check("rst err_pulse", err_pulse, 1'b0);
      check("rst sel_ch", sel_ch, 0);
      check_state("rst");
   endtask

   initial begin
      logic [7:0] c;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      do_reset();

      do_cmd("A", "selA", 1'b0);
      do_cmd("w", "incA", 1'b0);

      do_cmd("C", "selC", 1'b0);
      repeat (3) do_cmd("s", "decC", 1'b0);

      do_cmd("B", "selB", 1'b0);
      repeat (130) do_cmd("w", "satHi", 1'b0);
      repeat (260) do_cmd("s", "satLo", 1'b0);

      do_reset();
      do_cmd("w", "noSel", 1'b0);
      do_cmd("J", "badCh", 1'b0);

      do_cmd("A", "selA2", 1'b0);
      do_cmd("r", "busyDrop", 1'b1);

      // Reset in the middle of a multi-byte response.
      do_cmd("w", "preRst", 1'b0);
      @(negedge clk);
      bus.rx_data  = "w";
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      wait_bytes(1);
      check("midRst byte seen", rx_q.size() >= 1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check("midRst tx_start", bus.tx_start, 1'b0);
      check_state("midRst");
      rst = 1'b0;
      repeat (10) @(negedge clk);

      if (LOCK_EN) begin
         do_cmd("B", "lkSel", 1'b0);
         do_cmd("x", "lkOn", 1'b0);
         do_cmd("w", "lkDeny", 1'b0);
         do_cmd("x", "lkOff", 1'b0);
         do_cmd("w", "lkInc", 1'b0);
      end

      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: c = 8'(65 + $urandom_range(0, NUM_CH + 1));
            3, 4:    c = "w";
            5, 6:    c = "s";
            7:       c = "r";
            8:       c = "x";
            default: c = 8'($urandom_range(0, 255));
         endcase
         do_cmd(c, $sformatf("rnd%0d", n), ($urandom_range(0, 7) == 0) && (c == "r"));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
